// File: rtl/line_scanner_top.sv
// line_scanner_top: contact-image-sensor clocking, encoder/free-run line triggering,
// one-line 12-bit pixel capture and streaming.
module line_scanner_top #(
    parameter int CLK_DIV = 25,
    parameter int DUMMY   = 89,
    parameter int PIXELS  = 2592,
    parameter int FILT    = 4
) (
    input  logic        FPGA_CLK1_50,
    input  logic        RST,
    input  logic [11:0] DC_0,
    input  logic [2:0]  ENC_P,
    input  logic [2:0]  ENC_N,
    input  logic [3:0]  SW,
    output logic        CLKC_0,
    output logic        SCLKC_0,
    output logic        SIC_0,
    output logic [2:0]  LRGB_0,
    output logic [3:0]  LED,
    output logic [11:0] PIX_DATA,
    output logic        PIX_VALID,
    output logic        PIX_SOL,
    output logic        PIX_EOL
);
    localparam int LINE = DUMMY + PIXELS + 3;
    localparam int PW = $clog2(CLK_DIV);
    localparam int EW = $clog2(LINE + 1);
    localparam int FW = $clog2(FILT + 1);
    localparam logic [PW-1:0] PH_HI = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [EW-1:0] E_FIRST = EW'(DUMMY);
    localparam logic [EW-1:0] E_LAST = EW'(DUMMY + PIXELS - 1);
    localparam logic [EW-1:0] E_LINE = EW'(LINE);
    localparam logic [FW-1:0] F_LAST = FW'(FILT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SI, S_READ} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ph_q, ph_d;
    logic [EW-1:0]     ecnt_q, ecnt_d;
    logic [1:0]        sp1_q, sp_q, sn1_q, sn_q, ab_q, ab_d, div_q, div_d, lim, fwd, acc;
    logic [3:0]        sw1_q, sw_q, led_q, led_d;
    logic [1:0][FW-1:0] fc_q, fc_d;
    logic [FW-1:0]     flt_q, flt_d;
    logic [11:0]       pdat_q, pdat_d;
    logic              clkc_q, sclk_q, sic_q, lit_q, pend_q, pend_d, pval_q, psol_q, peol_q;
    logic              step, dbl, trig, fault, start, sample, last;
    logic              unused_index;

    assign unused_index = ENC_P[2] ^ ENC_N[2];

    always_comb begin
        ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
        acc = (sp_q ^ ab_q) & {fc_q[1] == F_LAST, fc_q[0] == F_LAST};
        fc_d[0] = (sp_q[0] == ab_q[0] || acc[0]) ? '0 : fc_q[0] + 1'b1;
        fc_d[1] = (sp_q[1] == ab_q[1] || acc[1]) ? '0 : fc_q[1] + 1'b1;
        ab_d = ab_q ^ acc;
        // Gray successor on {B,A}; SW[2] makes the opposite rotation count as forward
        fwd = sw_q[2] ? {~ab_q[0], ab_q[1]} : {ab_q[0], ~ab_q[1]};
        dbl = &acc;
        step = (acc != 2'b00) && !dbl && (ab_d == fwd);
        lim = (sw_q[1:0] == 2'd3) ? 2'd3 : (sw_q[1:0] == 2'd2) ? 2'd1 : 2'd0;
        trig = step && (sw_q[1:0] != 2'd0) && (div_q == lim);
        div_d = (sw1_q[1:0] != sw_q[1:0]) ? 2'd0 : !step ? div_q : (div_q == lim) ? 2'd0 : div_q + 2'd1;
        fault = (sp_q ^ sn_q) != 2'b11;
        flt_d = !fault ? '0 : (flt_q == F_LAST) ? flt_q : flt_q + 1'b1;
        // ecnt saturates at LINE after a line, which doubles as the minimum line-period gate
        start = (state_q == S_IDLE) && (ph_q == PH_HI) && (ecnt_q == E_LINE) && (sw_q[1:0] == 2'd0 || pend_q);
        sample = (state_q == S_READ) && (ph_q == PH_LAST) && (ecnt_q >= E_FIRST) && (ecnt_q <= E_LAST);
        last = sample && (ecnt_q == E_LAST);
        state_d = start ? S_SI : (state_q == S_SI && ph_q == PH_HI) ? S_READ : last ? S_IDLE : state_q;
        ecnt_d = start ? '0 : (ph_q == '0 && ecnt_q != E_LINE) ? ecnt_q + 1'b1 : ecnt_q;
        pend_d = start ? 1'b0 : (trig && state_q == S_IDLE) ? 1'b1 : pend_q;
        pdat_d = !sample ? pdat_q : sw_q[3] ? 12'(ecnt_q - E_FIRST) : DC_0 ^ 12'h800;
        led_d = {led_q[3:1] | {dbl, fault && flt_q == F_LAST, trig && (state_q != S_IDLE || pend_q)}, led_q[0] ^ last};
    end

    always_ff @(posedge FPGA_CLK1_50 or posedge RST) begin
        if (RST) begin
            ph_q    <= '0;
            clkc_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sp1_q   <= 2'b00;
            sp_q    <= 2'b00;
            sn1_q   <= 2'b11;
            sn_q    <= 2'b11;
            sw1_q   <= 4'h0;
            sw_q    <= 4'h0;
            fc_q    <= '0;
            ab_q    <= 2'b00;
            div_q   <= 2'd0;
            flt_q   <= '0;
            state_q <= S_IDLE;
            ecnt_q  <= E_LINE;
            pend_q  <= 1'b0;
            sic_q   <= 1'b0;
            lit_q   <= 1'b0;
            pval_q  <= 1'b0;
            psol_q  <= 1'b0;
            peol_q  <= 1'b0;
            pdat_q  <= 12'h000;
            led_q   <= 4'h0;
        end else begin
            ph_q    <= ph_d;
            clkc_q  <= ph_q < PH_HI;
            sclk_q  <= ~clkc_q;
            sp1_q   <= ENC_P[1:0];
            sp_q    <= sp1_q;
            sn1_q   <= ENC_N[1:0];
            sn_q    <= sn1_q;
            sw1_q   <= SW;
            sw_q    <= sw1_q;
            fc_q    <= fc_d;
            ab_q    <= ab_d;
            div_q   <= div_d;
            flt_q   <= flt_d;
            state_q <= state_d;
            ecnt_q  <= ecnt_d;
            pend_q  <= pend_d;
            sic_q   <= state_d == S_SI;
            lit_q   <= state_d != S_IDLE;
            pval_q  <= sample;
            psol_q  <= sample && (ecnt_q == E_FIRST);
            peol_q  <= last;
            pdat_q  <= pdat_d;
            led_q   <= led_d;
        end
    end

    assign CLKC_0    = clkc_q;
    assign SCLKC_0   = sclk_q;
    assign SIC_0     = sic_q;
    assign LRGB_0    = {3{lit_q}};
    assign LED       = led_q;
    assign PIX_DATA  = pdat_q;
    assign PIX_VALID = pval_q;
    assign PIX_SOL   = psol_q;
    assign PIX_EOL   = peol_q;
endmodule

// File: tb/tb_line_scanner_top.sv
// tb_line_scanner_top: directed checks of clocking, triggering, pixel capture and
// status flags with a shortened line (DUMMY=3, PIXELS=6).
module tb_line_scanner_top;
    localparam int CLK_DIV = 25;
    localparam int DUMMY = 3;
    localparam int PIXELS = 6;
    localparam int FILT = 4;
    localparam int LINE = DUMMY + PIXELS + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] DC_0 = 12'h000;
    logic [2:0]  ENC_P = 3'b000;
    logic [2:0]  ENC_N = 3'b111;
    logic [3:0]  SW = 4'b0011;
    logic        CLKC_0, SCLKC_0, SIC_0, PIX_VALID, PIX_SOL, PIX_EOL;
    logic [2:0]  LRGB_0;
    logic [3:0]  LED;
    logic [11:0] PIX_DATA;
    logic [1:0]  enc = 2'b00;
    int          cyc = 0;
    int          si_cyc = 0;
    int          total = 0;
    int          bad = 0;

    line_scanner_top #(.CLK_DIV(CLK_DIV), .DUMMY(DUMMY), .PIXELS(PIXELS), .FILT(FILT)) dut (
        .FPGA_CLK1_50(clk), .RST(rst), .DC_0(DC_0), .ENC_P(ENC_P), .ENC_N(ENC_N), .SW(SW),
        .CLKC_0(CLKC_0), .SCLKC_0(SCLKC_0), .SIC_0(SIC_0), .LRGB_0(LRGB_0), .LED(LED),
        .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_SOL(PIX_SOL), .PIX_EOL(PIX_EOL)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Apply n encoder steps 100 cycles apart, then a 400-cycle tail; count SI rises and pixels.
    task automatic steps(input int n, input logic rev, output int lines, output int pv);
        logic ps;
        lines = 0;
        pv = 0;
        ps = SIC_0;
        for (int s = 0; s < n + 4; s++) begin
            if (s < n) begin
                enc = rev ? {~enc[0], enc[1]} : {enc[0], ~enc[1]};
                ENC_P = {1'b0, enc};
                ENC_N = ~ENC_P;
            end
            repeat (100) begin
                @(negedge clk);
                if (SIC_0 && !ps) lines++;
                ps = SIC_0;
                if (PIX_VALID) pv++;
            end
        end
    endtask

    task automatic wait_si();
        int t;
        t = 0;
        while (SIC_0 && t < 1000) begin @(negedge clk); t++; end
        while (!SIC_0 && t < 1000) begin @(negedge clk); t++; end
        chk("si_wait_in_time", t < 1000, 1);
        si_cyc = cyc;
    endtask

    // Capture one line, driving the ramp source from observed sensor-clock edges.
    task automatic run_line(input logic pat);
        int edges, n, gap, wid, v;
        logic pc, l0;
        wait_si();
        chk("lrgb_at_si", LRGB_0, 7);
        l0 = LED[0];
        pc = CLKC_0;
        edges = 0;
        n = 0;
        gap = 0;
        wid = 1;
        for (int i = 0; i < LINE * CLK_DIV && n < PIXELS; i++) begin
            @(negedge clk);
            if (SIC_0) wid++;
            if (CLKC_0 && !pc) edges++;
            pc = CLKC_0;
            v = (edges < DUMMY) ? 1 : edges - DUMMY + 1;
            DC_0 = 12'(v) ^ 12'h800;
            gap++;
            if (PIX_VALID) begin
                chk("pix_data", PIX_DATA, pat ? n : n + 1);
                chk("pix_sol", PIX_SOL, n == 0);
                chk("pix_eol", PIX_EOL, n == PIXELS - 1);
                if (n > 0) chk("pix_spacing", gap, CLK_DIV);
                gap = 0;
                n++;
            end
        end
        chk("pix_count", n, PIXELS);
        chk("si_width", wid, CLK_DIV);
        chk("lrgb_after_read", LRGB_0, 0);
        chk("led0_toggle", LED[0], !l0);
    endtask

    initial begin
        int lines, pv, hc, sc, s1, t;
        cycles(3);
        chk("reset_outputs", {CLKC_0, SCLKC_0, SIC_0, LRGB_0, LED, PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("clkc_first_cycle", CLKC_0, 1);
        hc = 0;
        sc = 0;
        repeat (CLK_DIV) begin
            hc += int'(CLKC_0);
            sc += int'(SCLKC_0);
            @(negedge clk);
        end
        chk("clkc_high_count", hc, 12);
        chk("sclkc_high_count", sc, 13);
        steps(0, 1'b0, lines, pv);
        chk("no_trigger_lines", lines, 0);
        chk("no_trigger_pixels", pv, 0);

        steps(3, 1'b0, lines, pv);
        chk("mode3_3steps_lines", lines, 0);
        steps(1, 1'b0, lines, pv);
        chk("mode3_4th_step_lines", lines, 1);
        chk("mode3_4th_step_pixels", pv, PIXELS);
        chk("led_after_line1", LED, 4'b0001);
        steps(4, 1'b0, lines, pv);
        chk("mode3_next4_lines", lines, 1);
        chk("led_after_line2", LED, 4'b0000);

        SW = 4'b0001;
        cycles(5);
        steps(4, 1'b0, lines, pv);
        chk("mode1_fast_lines", lines, 2);
        chk("mode1_fast_pixels", pv, 2 * PIXELS);
        chk("overrun_led1", LED[1], 1);

        rst = 1'b1;
        SW = 4'b0111;
        cycles(2);
        chk("reset_clears_led", LED, 0);
        rst = 1'b0;
        cycles(5);
        steps(8, 1'b0, lines, pv);
        chk("rev_sense_fwd_lines", lines, 0);
        chk("rev_sense_fwd_pixels", pv, 0);
        steps(4, 1'b1, lines, pv);
        chk("rev_sense_rev_lines", lines, 1);
        chk("rev_sense_no_overrun", LED[1], 0);

        chk("flags_clear", LED[3:2], 0);
        ENC_P = 3'b011;
        ENC_N = 3'b100;
        cycles(20);
        chk("double_step_led3", LED[3], 1);
        ENC_P = 3'b000;
        ENC_N = 3'b111;
        cycles(20);
        ENC_N = 3'b000;
        cycles(2);
        ENC_N = 3'b111;
        cycles(10);
        chk("short_fault_ignored", LED[2], 0);
        ENC_N = 3'b000;
        cycles(10);
        ENC_N = 3'b111;
        cycles(5);
        chk("fault_led2", LED[2], 1);

        SW = 4'b1000;
        run_line(1'b1);
        s1 = si_cyc;
        wait_si();
        chk("freerun_line_period", si_cyc - s1, LINE * CLK_DIV);
        SW = 4'b0000;
        run_line(1'b0);

        t = 0;
        while (!PIX_VALID && t < 600) begin @(negedge clk); t++; end
        chk("midline_pixel_seen", t < 600, 1);
        rst = 1'b1;
        #1;
        chk("midline_reset_outputs", {CLKC_0, SCLKC_0, SIC_0, LRGB_0, LED, PIX_DATA, PIX_VALID, PIX_SOL, PIX_EOL}, 0);
        SW = 4'b0011;
        cycles(3);
        rst = 1'b0;
        steps(0, 1'b0, lines, pv);
        chk("post_reset_no_pixels", pv, 0);
        chk("post_reset_no_lines", lines, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_scanner_top.md
# line_scanner_top

Line-scan camera core: generates the contact-image-sensor clock and start pulse, captures one line of 12-bit ADC pixels per trigger, and streams them out. Line triggers come from a differential quadrature encoder, decimated by switch setting, or from free-run. Sits at the FPGA top level between the sensor/ADC pins, the encoder receiver and the downstream pixel consumer.

## Interface
- CLK_DIV, 25: system cycles per sensor clock period (50 MHz / 25 = 2 MHz)
- DUMMY, 89: sensor clock rising edges after SI before the first valid pixel
- PIXELS, 2592: valid pixels per line
- FILT, 4: encoder glitch-filter length, system cycles

- FPGA_CLK1_50  in  1  sole clock, 50 MHz; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- DC_0  in  12  ADC data, offset-binary with inverted MSB
- ENC_P  in  3  encoder positive lines: [0]=A, [1]=B, [2]=index (unused)
- ENC_N  in  3  encoder complementary lines
- SW  in  4  [1:0] trigger mode, [2] reverse direction sense, [3] test pattern
- CLKC_0  out  1  sensor clock
- SCLKC_0  out  1  ADC sample clock
- SIC_0  out  1  sensor start-integration pulse
- LRGB_0  out  3  illumination enables
- LED  out  4  status
- PIX_DATA  out  12  captured pixel
- PIX_VALID  out  1  one-cycle pixel strobe
- PIX_SOL  out  1  with first pixel of line
- PIX_EOL  out  1  with last pixel of line

## Operation
- Phase counter ph cycles 0..CLK_DIV-1. CLKC_0=1 for ph 0..11, 0 for ph 12..24 (registered). SCLKC_0 = registered inverse of CLKC_0.
- Encoder: ENC_P[1:0] through 2-FF sync, then filter (new level accepted after FILT consecutive equal samples). Forward step = A/B Gray step with A leading B (00→01→11→10→00 on {B,A}); SW[2] swaps forward/reverse. Reverse steps ignored. Both bits changing at once: no step, set LED[3].
- Fault: ENC_P[i]==ENC_N[i] (i=0,1) for FILT synced cycles sets LED[2].
- Trigger mode SW[1:0]: 0 free-run (new line as soon as idle); 1 every forward step; 2 every 2nd; 3 every 4th. Step divider resets to 0 on reset and on mode change.
- Line FSM: IDLE → SI (trigger pending, start at ph 12) → READ → IDLE. SIC_0 high for exactly CLK_DIV cycles from ph 12. Sensor rising edges counted from 1 after SI rise; pixel i (0..PIXELS-1) is sampled at ph 24 of the period following edge DUMMY+i. READ ends after pixel PIXELS-1; next SI no earlier than 3 sensor periods after edge DUMMY+PIXELS-1 (min line = 2684 periods).
- Trigger while not IDLE: dropped, set LED[1] (overrun). At most one pending trigger.
- PIX_DATA = DC_0 ^ 12'h800; with SW[3]=1, PIX_DATA = i[11:0]. PIX_SOL with i=0, PIX_EOL with i=PIXELS-1.
- LRGB_0 = 3'b111 from SI rise until READ end, else 0.
- LED[0] toggles each completed line; LED[3:1] sticky until reset.

## Timing
- Reset values: ph=0, CLKC_0=0, SCLKC_0=0, SIC_0=0, LRGB_0=0, LED=0, PIX_*=0, FSM IDLE, divider 0. First CLKC_0 rise at first cycle after RST release.
- PIX_VALID/PIX_DATA registered: one cycle after the ph 24 sample; PIX_VALID high exactly 1 cycle per pixel, PIXELS strobes per line, spaced CLK_DIV cycles.
- Trigger latency: filtered step → SI rise at next ph 12 (≤2+FILT+CLK_DIV cycles).
- RST mid-line: line aborted immediately, no further PIX_VALID; sticky LEDs cleared.

## Test plan
- Ramp source: after SI rise hold DC_0=1^0x800 for 89 sensor edges, then +1 per edge → 2592 pixels valued 1..2592, SOL on 1, EOL on 2592, no SW[3].
- SW=4'b0011, encoder 820 pps, one phase toggle per step (A then B) → one line per 4 steps, LED[1]=0, LED[0] toggles per line.
- SW=4'b0001 at 820 pps (2439 sensor periods/step < 2684) → some triggers dropped, LED[1]=1.
- pps stepped 820→100→500→700 under SW=0011 → every 4th step yields a line, no overrun.
- SW[2]=1 with same sequence → no lines; ENC_N=ENC_P held → LED[2]=1; A,B toggled together → LED[3]=1.
- SW=4'b1000 free-run → back-to-back lines every 2684 periods, PIX_DATA=0..2591; RST mid-line → all outputs 0 immediately.
